mux_arb: RTL and testbench

- 2-to-1 stream merger: the inverse of `dmux`. It joins two valid/ready producer streams (a, b) into one consumer stream (y).
- Fair round-robin arbitration when both inputs request.
- Single registered output stage, so throughput is one beat per cycle.
- Sits in the basic-gates library as the sequential companion to `dmux`. It feeds a shared downstream path from two sources.

---
 rtl/mux_arb_pkg.sv | 38 +++
 rtl/rr_arb2.sv | 72 +++++++
 rtl/mux_arb.sv | 100 ++++++++++
 tb/tb_mux_arb.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared source encoding and the round-robin pick helper
// used by the 2-to-1 stream merger (mux_arb) and its arbiter (rr_arb2).
// The source encoding macros are shared with the dmux benches.
// Optional feature macro: MUX_ARB_LOCK_EN (packet lock, see rr_arb2/mux_arb).

`ifndef MUX_SRC_A
`define MUX_SRC_A 1'b0
`endif
`ifndef MUX_SRC_B
`define MUX_SRC_B 1'b1
`endif

package mux_arb_pkg;

  // Identity of a merger input; also the encoding driven on y_src.
  typedef enum logic {
    SRC_A = `MUX_SRC_A,
    SRC_B = `MUX_SRC_B
  } src_e;

  // Request/grant vector bit positions.
  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

  // One-hot (or zero) grant: a lone requester wins, on contention the
  // input that did not win the last transfer wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input src_e last);
    logic [1:0] g;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = (last == SRC_B) ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter with a transfer-driven
// pointer. The pointer moves only when the caller reports an actual
// transfer (advance), never on a grant alone.
// Optional feature macro: MUX_ARB_LOCK_EN adds a packet lock that keeps
// the grant on one source until it transfers a beat flagged as last.

module rr_arb2
  import mux_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
`ifdef MUX_ARB_LOCK_EN
  input  logic       advance_last,
`endif
  output logic [1:0] gnt
);

  src_e last_r;
  src_e gnt_src;

`ifdef MUX_ARB_LOCK_EN
  logic locked_r;
  src_e lock_src_r;
`endif

  // Combinational grant: round-robin pick, overridden by an active lock.
  always_comb begin
    gnt = rr_pick(req, last_r);
`ifdef MUX_ARB_LOCK_EN
    if (locked_r) begin
      if (lock_src_r == SRC_A) begin
        gnt = {1'b0, req[REQ_A]};
      end else begin
        gnt = {req[REQ_B], 1'b0};
      end
    end else begin
      gnt = rr_pick(req, last_r);
    end
`endif
    gnt_src = gnt[REQ_B] ? SRC_B : SRC_A;
  end

  // Pointer register: remembers the source of the most recent transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= SRC_B;
    end else if (advance) begin
      last_r <= gnt_src;
    end else begin
      last_r <= last_r;
    end
  end

`ifdef MUX_ARB_LOCK_EN
  // Lock register: a non-final beat locks onto its source, a final beat releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_r   <= 1'b0;
      lock_src_r <= SRC_A;
    end else if (advance) begin
      locked_r   <= ~advance_last;
      lock_src_r <= gnt_src;
    end else begin
      locked_r   <= locked_r;
      lock_src_r <= lock_src_r;
    end
  end
`endif

endmodule

// File: rtl/mux_arb.sv
// mux_arb: 2-to-1 valid/ready stream merger with fair round-robin
// arbitration and a single registered output stage (one beat per cycle,
// drain and refill in the same cycle).
// Optional feature macro: MUX_ARB_LOCK_EN adds a_last/b_last/y_last and
// keeps the grant on one input for the length of a packet.

module mux_arb
  import mux_arb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [W-1:0] a_data,
`ifdef MUX_ARB_LOCK_EN
  input  logic         a_last,
`endif
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [W-1:0] b_data,
`ifdef MUX_ARB_LOCK_EN
  input  logic         b_last,
`endif
  output logic         y_valid,
  input  logic         y_ready,
  output logic [W-1:0] y_data,
`ifdef MUX_ARB_LOCK_EN
  output logic         y_last,
`endif
  output logic         y_src
);

  logic [1:0] req;
  logic [1:0] gnt;
  logic       can_load;
  logic       xfer_a;
  logic       xfer_b;
  logic       advance;
`ifdef MUX_ARB_LOCK_EN
  logic       advance_last;
`endif

  rr_arb2 u_arb (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .advance      (advance),
`ifdef MUX_ARB_LOCK_EN
    .advance_last (advance_last),
`endif
    .gnt          (gnt)
  );

  // Handshake: readies come from the grant and the output slot, never while in reset.
  always_comb begin
    req      = {b_valid, a_valid};
    can_load = ~y_valid | y_ready;
    a_ready  = ~rst & can_load & gnt[REQ_A];
    b_ready  = ~rst & can_load & gnt[REQ_B];
    xfer_a   = a_valid & a_ready;
    xfer_b   = b_valid & b_ready;
    advance  = xfer_a | xfer_b;
`ifdef MUX_ARB_LOCK_EN
    advance_last = xfer_b ? b_last : a_last;
`endif
  end

  // Output stage: load on transfer, empty on drain without refill, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_valid <= 1'b0;
      y_data  <= {W{1'b0}};
      y_src   <= SRC_A;
`ifdef MUX_ARB_LOCK_EN
      y_last  <= 1'b0;
`endif
    end else if (xfer_a) begin
      y_valid <= 1'b1;
      y_data  <= a_data;
      y_src   <= SRC_A;
`ifdef MUX_ARB_LOCK_EN
      y_last  <= a_last;
`endif
    end else if (xfer_b) begin
      y_valid <= 1'b1;
      y_data  <= b_data;
      y_src   <= SRC_B;
`ifdef MUX_ARB_LOCK_EN
      y_last  <= b_last;
`endif
    end else if (y_valid && y_ready) begin
      y_valid <= 1'b0;
    end else begin
      y_valid <= y_valid;
    end
  end

endmodule

// File: tb/tb_mux_arb.sv
// tb_mux_arb: table-driven directed bench for mux_arb. Each record holds
// the inputs for one cycle, the expected combinational readies during
// that cycle and the expected registered y outputs after the edge.
// With MUX_ARB_LOCK_EN defined, a hand-written packet-lock sequence runs too.

module tb_mux_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, b_valid, y_ready;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, y_valid, y_src;
  logic [7:0] y_data;
`ifdef MUX_ARB_LOCK_EN
  logic       a_last, b_last, y_last;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_arb #(.W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_data  (a_data),
`ifdef MUX_ARB_LOCK_EN
    .a_last  (a_last),
`endif
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_data  (b_data),
`ifdef MUX_ARB_LOCK_EN
    .b_last  (b_last),
`endif
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_data  (y_data),
`ifdef MUX_ARB_LOCK_EN
    .y_last  (y_last),
`endif
    .y_src   (y_src)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       yr;
    logic       e_ar;
    logic       e_br;
    logic       e_yv;
    logic [7:0] e_yd;
    logic       e_ys;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic r, logic av, logic [7:0] ad,
                              logic bv, logic [7:0] bd, logic yr,
                              logic e_ar, logic e_br, logic e_yv,
                              logic [7:0] e_yd, logic e_ys);
    vec_t v;
    v.name = name; v.rst = r; v.av = av; v.ad = ad; v.bv = bv; v.bd = bd;
    v.yr = yr; v.e_ar = e_ar; v.e_br = e_br; v.e_yv = e_yv; v.e_yd = e_yd;
    v.e_ys = e_ys;
    return v;
  endfunction

  task automatic check(string name, logic [7:0] got, logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs, check readies mid-cycle, then y after the edge.
  task automatic apply(vec_t v);
    rst = v.rst; a_valid = v.av; a_data = v.ad;
    b_valid = v.bv; b_data = v.bd; y_ready = v.yr;
    #1;
    check({v.name, " a_ready"}, {7'd0, a_ready}, {7'd0, v.e_ar});
    check({v.name, " b_ready"}, {7'd0, b_ready}, {7'd0, v.e_br});
    @(posedge clk);
    #1;
    check({v.name, " y_valid"}, {7'd0, y_valid}, {7'd0, v.e_yv});
    check({v.name, " y_data"}, y_data, v.e_yd);
    check({v.name, " y_src"}, {7'd0, y_src}, {7'd0, v.e_ys});
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0;
    a_data = 8'h00; b_data = 8'h00;
`ifdef MUX_ARB_LOCK_EN
    a_last = 1'b1; b_last = 1'b1;
`endif

    //                 name        rst   av    ad     bv    bd     yr    ar    br    yv    yd     ys
    vecs.push_back(mk("rst0",     1'b1, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
    vecs.push_back(mk("rst1",     1'b1, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
    // single source back-to-back
    vecs.push_back(mk("single1",  1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0));
    vecs.push_back(mk("single2",  1'b0, 1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0));
    vecs.push_back(mk("single3",  1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0));
    // drain without refill: data and source hold
    vecs.push_back(mk("drain",    1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0));
    // fresh pointer, then contention alternates A,B,...
    vecs.push_back(mk("rst2",     1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
    vecs.push_back(mk("cont1",    1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0));
    vecs.push_back(mk("cont2",    1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1, 1'b0, 1'b1, 1'b1, 8'hBB, 1'b1));
    vecs.push_back(mk("cont3",    1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0));
    vecs.push_back(mk("cont4",    1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1, 1'b0, 1'b1, 1'b1, 8'hBB, 1'b1));
    vecs.push_back(mk("cont5",    1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0));
    vecs.push_back(mk("cont6",    1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1, 1'b0, 1'b1, 1'b1, 8'hBB, 1'b1));
    // backpressure: load 0x5A, stall 4 cycles, then drain+refill with B
    vecs.push_back(mk("bp_load",  1'b0, 1'b1, 8'h5A, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0));
    vecs.push_back(mk("bp_hold1", 1'b0, 1'b1, 8'h66, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0));
    vecs.push_back(mk("bp_hold2", 1'b0, 1'b1, 8'h66, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0));
    vecs.push_back(mk("bp_hold3", 1'b0, 1'b1, 8'h66, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0));
    vecs.push_back(mk("bp_hold4", 1'b0, 1'b1, 8'h66, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0));
    vecs.push_back(mk("bp_go",    1'b0, 1'b1, 8'h66, 1'b1, 8'hBB, 1'b1, 1'b0, 1'b1, 1'b1, 8'hBB, 1'b1));
    // drain+refill from A (pointer at B), then mid-operation reset
    vecs.push_back(mk("pre_rst",  1'b0, 1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0));
    vecs.push_back(mk("mid_rst",  1'b1, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
    vecs.push_back(mk("post_rst", 1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

`ifdef MUX_ARB_LOCK_EN
    // Packet lock: A sends 3 beats (last on the 3rd) with a gap, B waits.
    a_last = 1'b1; b_last = 1'b1;
    apply(mk("lk_rst",  1'b1, 1'b0, 8'h00, 1'b1, 8'hBB, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
    check("lk_rst y_last", {7'd0, y_last}, 8'h00);
    a_last = 1'b0;
    apply(mk("lk_a1",   1'b0, 1'b1, 8'h01, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0));
    check("lk_a1 y_last", {7'd0, y_last}, 8'h00);
    apply(mk("lk_gap",  1'b0, 1'b0, 8'h00, 1'b1, 8'hBB, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0));
    apply(mk("lk_a2",   1'b0, 1'b1, 8'h02, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0));
    a_last = 1'b1;
    apply(mk("lk_a3",   1'b0, 1'b1, 8'h03, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0));
    check("lk_a3 y_last", {7'd0, y_last}, 8'h01);
    a_last = 1'b0;
    apply(mk("lk_b",    1'b0, 1'b1, 8'h04, 1'b1, 8'hBB, 1'b1, 1'b0, 1'b1, 1'b1, 8'hBB, 1'b1));
    check("lk_b y_last", {7'd0, y_last}, 8'h01);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
